// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the 65C02 core and
// one DMA requester. DMA bursts are capped at MAX_BURST cycles, after which
// the CPU is guaranteed HOLDOFF cycles of bus ownership.
//
// Handshake: dma_req is a level request held high while transfers are
// wanted. dma_ack=1 marks a cycle whose memory access belongs to DMA; that
// access completes at the next rising edge. The requester must drop dma_req
// in the same cycle as its last wanted ack. cpu_rdy=0 freezes the CPU core,
// which then holds AB/DO/WE steady until the bus comes back.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic        burst_active
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_DMA  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Terminal counts; both parameters are bounded to 1..255 so 8 bits suffice.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] burst_cnt;
  logic [7:0] burst_cnt_next;
  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_next;

  // State register, burst/hold counters and the registered debug flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CPU;
      burst_cnt    <= 8'd0;
      hold_cnt     <= 8'd0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_next;
      burst_cnt    <= burst_cnt_next;
      hold_cnt     <= hold_cnt_next;
      burst_active <= (state_next == ST_DMA);
    end
  end

  // Next-state and counter update; dma_req is only looked at where it matters.
  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    hold_cnt_next  = hold_cnt;
    case (state)
      ST_CPU: begin
        if (dma_req) begin
          state_next     = ST_DMA;
          burst_cnt_next = 8'd0;
        end
      end
      ST_DMA: begin
        burst_cnt_next = burst_cnt + 8'd1;
        // A dropped request takes priority over reaching the burst limit.
        if (!dma_req) begin
          state_next = ST_CPU;
        end else if (burst_cnt == BURST_LAST) begin
          state_next    = ST_HOLD;
          hold_cnt_next = 8'd0;
        end
      end
      ST_HOLD: begin
        hold_cnt_next = hold_cnt + 8'd1;
        if (hold_cnt == HOLD_LAST) begin
          if (dma_req) begin
            state_next     = ST_DMA;
            burst_cnt_next = 8'd0;
          end else begin
            state_next = ST_CPU;
          end
        end
      end
      default: begin
        state_next = ST_CPU;
      end
    endcase
  end

  // Bus mux and handshake outputs; mem_we is gated by reset so an in-flight
  // write is abandoned the moment reset asserts.
  always_comb begin
    mem_addr = cpu_ab;
    mem_din  = cpu_do;
    mem_we   = cpu_we & reset_n;
    cpu_rdy  = 1'b1;
    dma_ack  = 1'b0;
    if (state == ST_DMA) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
      mem_we   = dma_we & reset_n;
      cpu_rdy  = 1'b0;
      dma_ack  = 1'b1;
    end
    cpu_di    = mem_dout;
    dma_rdata = mem_dout;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MAX_BURST=4, HOLDOFF=2 and a
// behavioural 64 KiB memory (combinational read, synchronous write).
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        burst_active;

  logic [7:0]  mem [0:65535];

  int checks;
  int errors;

  mem_bus_arbiter #(.MAX_BURST(4), .HOLDOFF(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_ab       (cpu_ab),
    .cpu_do       (cpu_do),
    .cpu_we       (cpu_we),
    .cpu_di       (cpu_di),
    .cpu_rdy      (cpu_rdy),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_we       (dma_we),
    .dma_ack      (dma_ack),
    .dma_rdata    (dma_rdata),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout),
    .burst_active (burst_active)
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cpu_ab    = 16'hFFFC;
    cpu_do    = 8'h00;
    cpu_we    = 1'b1;
    dma_req   = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    dma_we    = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL reset_dma_ack got=%b exp=0", dma_ack); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst_active got=%b exp=0", burst_active); end
    step();
    step();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_hold_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 16'hFFFC) begin errors++; $display("FAIL reset_mem_addr got=%h exp=fffc", mem_addr); end
    reset_n = 1'b1;
    cpu_we  = 1'b0;
    step();
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL idle_cpu_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (mem_addr !== 16'hFFFC) begin errors++; $display("FAIL idle_mem_addr got=%h exp=fffc", mem_addr); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL idle_burst_active got=%b exp=0", burst_active); end
  endtask

  task automatic test_single_write();
    cpu_ab    = 16'h1234;
    cpu_we    = 1'b0;
    dma_req   = 1'b1;
    dma_addr  = 16'h2000;
    dma_wdata = 8'h5A;
    dma_we    = 1'b1;
    #1;
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_latency got=%b exp=0", dma_ack); end
    step();
    checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", dma_ack); end
    checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL wr_cpu_rdy got=%b exp=0", cpu_rdy); end
    checks++; if (mem_addr !== 16'h2000) begin errors++; $display("FAIL wr_mem_addr got=%h exp=2000", mem_addr); end
    checks++; if (mem_din !== 8'h5A) begin errors++; $display("FAIL wr_mem_din got=%h exp=5a", mem_din); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
    checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL wr_burst_active got=%b exp=1", burst_active); end
    dma_req = 1'b0;
    step();
    dma_we = 1'b0;
    #1;
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_end got=%b exp=0", dma_ack); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy_end got=%b exp=1", cpu_rdy); end
    checks++; if (mem[16'h2000] !== 8'h5A) begin errors++; $display("FAIL wr_mem_data got=%h exp=5a", mem[16'h2000]); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL wr_cpu_ab_back got=%h exp=1234", mem_addr); end
  endtask

  task automatic test_dma_read();
    // Preload through the CPU path.
    cpu_ab = 16'h3001;
    cpu_do = 8'hC3;
    cpu_we = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL cpu_wr_mem_we got=%b exp=1", mem_we); end
    step();
    cpu_we   = 1'b0;
    cpu_ab   = 16'h0100;
    dma_req  = 1'b1;
    dma_addr = 16'h3001;
    dma_we   = 1'b0;
    step();
    checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", dma_ack); end
    checks++; if (dma_rdata !== 8'hC3) begin errors++; $display("FAIL rd_rdata got=%h exp=c3", dma_rdata); end
    checks++; if (cpu_di !== 8'hC3) begin errors++; $display("FAIL rd_cpu_di got=%h exp=c3", cpu_di); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL rd_cpu_rdy got=%b exp=0", cpu_rdy); end
    dma_req = 1'b0;
    step();
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rd_rdy_end got=%b exp=1", cpu_rdy); end
  endtask

  task automatic test_burst_limit();
    // Cycles 1..20 after req rises: 4 DMA, 2 HOLD, repeating.
    logic [19:0] exp_pat;
    logic        exp_ack;
    exp_pat  = 20'b1111_0011_1100_1111_0011;
    cpu_ab   = 16'h1234;
    dma_addr = 16'h4000;
    dma_we   = 1'b0;
    dma_req  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_ack = exp_pat[20 - k];
      checks++; if (dma_ack !== exp_ack) begin errors++; $display("FAIL burst_ack cyc=%0d got=%b exp=%b", k, dma_ack, exp_ack); end
      checks++; if (cpu_rdy !== !exp_ack) begin errors++; $display("FAIL burst_rdy cyc=%0d got=%b exp=%b", k, cpu_rdy, !exp_ack); end
      checks++; if (mem_addr !== (exp_ack ? 16'h4000 : 16'h1234)) begin errors++; $display("FAIL burst_addr cyc=%0d got=%h exp=%h", k, mem_addr, (exp_ack ? 16'h4000 : 16'h1234)); end
    end
    dma_req = 1'b0;
    step();
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL burst_end_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL burst_end_active got=%b exp=0", burst_active); end
  endtask

  task automatic test_coincident_drop();
    dma_addr = 16'h4100;
    dma_we   = 1'b0;
    dma_req  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL coinc_ack cyc=%0d got=%b exp=1", k, dma_ack); end
    end
    // Drop in the 4th DMA cycle, where the burst limit is also reached.
    dma_req = 1'b0;
    step();
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL coinc_active got=%b exp=0", burst_active); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL coinc_rdy got=%b exp=1", cpu_rdy); end
    // From CPU a new request is granted on the next cycle; HOLD would delay it.
    dma_req = 1'b1;
    step();
    checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL coinc_regrant got=%b exp=1", dma_ack); end
    dma_req = 1'b0;
    step();
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL coinc_regrant_end got=%b exp=0", dma_ack); end
  endtask

  task automatic test_async_reset();
    dma_addr  = 16'h5000;
    dma_wdata = 8'hA5;
    dma_we    = 1'b0;
    dma_req   = 1'b1;
    step();
    step();
    step();
    // Third DMA cycle: make it a write, then reset off the clock edge.
    dma_we = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ares_pre_we got=%b exp=1", mem_we); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL ares_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ares_mem_we got=%b exp=0", mem_we); end
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL ares_ack got=%b exp=0", dma_ack); end
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL ares_active got=%b exp=0", burst_active); end
    step();
    dma_req = 1'b0;
    dma_we  = 1'b0;
    reset_n = 1'b1;
    step();
    checks++; if (burst_active !== 1'b0) begin errors++; $display("FAIL ares_state got=%b exp=0", burst_active); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL ares_rdy_after got=%b exp=1", cpu_rdy); end
    checks++; if (mem[16'h5000] === 8'hA5) begin errors++; $display("FAIL ares_no_write got=%h exp=not a5", mem[16'h5000]); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_dma_read();
    test_burst_limit();
    test_coincident_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
